// File: rtl/enc_sample_ctrl_pkg.sv
// Shared constants and types for the encoder sampling scheduler.
// Status-word layout is defined here so RTL and host software agree on it.
package enc_pkg;

  localparam int N_CH           = 4;
  localparam int WIDTH          = 16;
  localparam int DEFAULT_PERIOD = 500000;
  localparam int SEQ_W          = 8;

  localparam int ST_SEQ_LSB = 0;
  localparam int ST_PENDING = 8;
  localparam int ST_OVERRUN = 9;
  localparam int ST_LOCK    = 10;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    TICK,
    CAPTURE
  } encState_t;

  typedef logic [N_CH*WIDTH-1:0] packedCount_t;

endpackage

// File: rtl/enc_sample_ctrl_if.sv
// Host readout port of the sampling scheduler: bank lock handshake, word
// reads and snapshot status. The host side is master, the scheduler slave.
interface enc_sample_ctrl_if #(
  parameter int N_CH  = enc_pkg::N_CH,
  parameter int WIDTH = enc_pkg::WIDTH
);
  import enc_pkg::*;

  localparam int ADDR_W = $clog2(N_CH + 1);

  logic              lock_req;
  logic              lock_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              snap_valid;
  logic [SEQ_W-1:0]  snap_seq;
  logic              overrun;
  logic              clr_ovr;

  modport master (
    output lock_req, rd_addr, clr_ovr,
    input  lock_ack, rd_data, snap_valid, snap_seq, overrun
  );

  modport slave (
    input  lock_req, rd_addr, clr_ovr,
    output lock_ack, rd_data, snap_valid, snap_seq, overrun
  );

endinterface

// File: rtl/enc_sample_ctrl_window_timer.sv
// Measurement-window counter: counts 0..PERIOD-1 while enabled and flags the
// terminal cycle (tick) plus the cycle before it (preTick) for the FSM.
module enc_window_timer #(
  parameter int PERIOD = enc_pkg::DEFAULT_PERIOD
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick,
  output logic preTick
);
  import enc_pkg::*;

  localparam int CW = $clog2(PERIOD);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == CW'(PERIOD - 1)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // preTick lets the FSM enter TICK in the same cycle the tick is driven
  assign tick    = enable && (count == CW'(PERIOD - 1));
  assign preTick = enable && (count == CW'(PERIOD - 2));

endmodule

// File: rtl/enc_sample_ctrl.sv
// Encoder sampling scheduler: window tick generation, coherent capture into a
// front/shadow bank pair, and a lockable tear-free readout for the host.
module enc_sample_ctrl #(
  parameter int N_CH   = enc_pkg::N_CH,
  parameter int WIDTH  = enc_pkg::WIDTH,
  parameter int PERIOD = enc_pkg::DEFAULT_PERIOD
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic                  sample_tick,
  input  logic [N_CH*WIDTH-1:0] cnt_in,
  enc_sample_ctrl_if.slave      host
);
  import enc_pkg::*;

  localparam int ADDR_W = $clog2(N_CH + 1);

  encState_t state;
  encState_t stateNext;

  logic timerTick;
  logic timerPreTick;

  logic             lockAck;
  logic             pending;
  logic             snapValid;
  logic [SEQ_W-1:0] snapSeq;
  logic             overrun;
  logic [WIDTH-1:0] rdData;
  logic [WIDTH-1:0] readNext;
  logic [WIDTH-1:0] statusWord;

  logic [N_CH*WIDTH-1:0] frontFlat;

  logic captureNow;
  logic releaseNow;
  logic frontFromCnt;
  logic frontFromShadow;
  logic shadowFromCnt;

  enc_window_timer #(
    .PERIOD (PERIOD)
  ) uTimer (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (timerTick),
    .preTick (timerPreTick)
  );

  assign sample_tick = timerTick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (enable) stateNext = COUNT;
      COUNT: begin
        if (!enable)          stateNext = IDLE;
        else if (timerPreTick) stateNext = TICK;
      end
      TICK:    stateNext = CAPTURE;
      CAPTURE: stateNext = enable ? COUNT : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // A release edge coinciding with capture publishes the fresh capture
  // directly, so the shadow is only written while the lock stays held.
  assign captureNow      = (state == CAPTURE);
  assign releaseNow      = lockAck && !host.lock_req;
  assign frontFromCnt    = captureNow && (!lockAck || releaseNow);
  assign shadowFromCnt   = captureNow && lockAck && !releaseNow;
  assign frontFromShadow = !captureNow && releaseNow && pending;

  for (genvar gi = 0; gi < N_CH; gi++) begin : gBank
    logic [WIDTH-1:0] frontReg;
    logic [WIDTH-1:0] shadowReg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        frontReg  <= '0;
        shadowReg <= '0;
      end else begin
        if (frontFromCnt)         frontReg <= cnt_in[gi*WIDTH +: WIDTH];
        else if (frontFromShadow) frontReg <= shadowReg;
        if (shadowFromCnt)        shadowReg <= cnt_in[gi*WIDTH +: WIDTH];
      end
    end

    assign frontFlat[gi*WIDTH +: WIDTH] = frontReg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lockAck   <= 1'b0;
      pending   <= 1'b0;
      snapValid <= 1'b0;
      snapSeq   <= '0;
      overrun   <= 1'b0;
    end else begin
      lockAck <= host.lock_req;
      if (host.clr_ovr) overrun <= 1'b0;
      if (frontFromCnt) begin
        snapSeq   <= snapSeq + 1'b1;
        snapValid <= 1'b1;
        pending   <= 1'b0;
        if (lockAck && pending) overrun <= 1'b1;
      end else if (shadowFromCnt) begin
        if (pending) overrun <= 1'b1;
        pending <= 1'b1;
      end else if (frontFromShadow) begin
        snapSeq   <= snapSeq + 1'b1;
        snapValid <= 1'b1;
        pending   <= 1'b0;
      end
    end
  end

  always_comb begin
    statusWord = '0;
    statusWord[ST_SEQ_LSB +: SEQ_W] = snapSeq;
    statusWord[ST_PENDING]          = pending;
    statusWord[ST_OVERRUN]          = overrun;
    statusWord[ST_LOCK]             = lockAck;
  end

  // Addresses past the status word read as zero
  always_comb begin
    readNext = '0;
    if (host.rd_addr == ADDR_W'(N_CH)) readNext = statusWord;
    for (int k = 0; k < N_CH; k++) begin
      if (host.rd_addr == ADDR_W'(k)) readNext = frontFlat[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdData <= '0;
    end else begin
      rdData <= readNext;
    end
  end

  assign host.lock_ack   = lockAck;
  assign host.snap_valid = snapValid;
  assign host.snap_seq   = snapSeq;
  assign host.overrun    = overrun;
  assign host.rd_data    = rdData;

endmodule

// File: tb/tb_enc_sample_ctrl.sv
// Directed bench for enc_sample_ctrl with PERIOD=10: windowing, capture,
// lock/release, overrun, sequence wrap, enable gating and async reset.
module tb_enc_sample_ctrl;
  import enc_pkg::*;

  localparam int P = 10;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic         sample_tick;
  packedCount_t cntIn = '0;

  enc_sample_ctrl_if #(.N_CH(N_CH), .WIDTH(WIDTH)) host();

  enc_sample_ctrl #(
    .N_CH   (N_CH),
    .WIDTH  (WIDTH),
    .PERIOD (P)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .sample_tick (sample_tick),
    .cnt_in      (cntIn),
    .host        (host)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } rdExp_t;

  rdExp_t     sbQ[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] expSeq = 8'd0;

  function automatic logic [15:0] statusW(input logic [7:0] seq, input logic pend,
                                          input logic ovr, input logic lk);
    return {5'd0, lk, ovr, pend, seq};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("ok   %s obs=%0h exp=%0h", tag, obs, exp);
    end else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits (bounded) for the next tick; optionally checks the edge count.
  task automatic waitTick(input string tag, input int expEdges);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!sample_tick && n < 50);
    check({tag, "_tick"}, sample_tick, 1);
    if (expEdges >= 0) check({tag, "_gap"}, n, expEdges);
  endtask

  task automatic rd(input string tag, input logic [2:0] addr, input logic [15:0] exp);
    rdExp_t e;
    host.rd_addr = addr;
    sbQ.push_back('{tag, exp});
    @(posedge clk);
    #1;
    e = sbQ.pop_front();
    check(e.tag, host.rd_data, e.val);
  endtask

  task automatic setCh(input int ch, input logic [15:0] v);
    cntIn[ch*16 +: 16] = v;
  endtask

  initial begin
    int tickCount;
    host.lock_req = 1'b0;
    host.clr_ovr  = 1'b0;
    host.rd_addr  = '0;
    enable        = 1'b1;
    setCh(0, 16'h0005);
    setCh(1, 16'hFFFE);
    setCh(2, 16'h7FFF);
    setCh(3, 16'h8000);

    // Reset state
    @(posedge clk);
    #1;
    check("rst_tick", sample_tick, 0);
    check("rst_ack", host.lock_ack, 0);
    check("rst_rd", host.rd_data, 16'h0000);
    check("rst_valid", host.snap_valid, 0);
    check("rst_seq", host.snap_seq, 8'd0);
    check("rst_ovr", host.overrun, 0);
    reset_n = 1'b1;

    // Windowing: first tick in the PERIOD-th cycle, then every PERIOD cycles
    waitTick("t1", P - 1);
    step(1);
    check("t1_pulse", sample_tick, 0);
    step(1);
    expSeq++;
    check("t1_seq", host.snap_seq, expSeq);
    check("t1_valid", host.snap_valid, 1);

    // Bit-exact readout of the first capture
    rd("rd_ch0", 3'd0, 16'h0005);
    rd("rd_ch1", 3'd1, 16'hFFFE);
    rd("rd_ch2", 3'd2, 16'h7FFF);
    rd("rd_ch3", 3'd3, 16'h8000);
    rd("rd_stat", 3'd4, statusW(expSeq, 0, 0, 0));
    rd("rd_oob", 3'd7, 16'h0000);

    waitTick("t2", 2);
    step(2);
    expSeq++;
    check("t2_seq", host.snap_seq, expSeq);
    waitTick("t3", P - 2);
    step(2);
    expSeq++;
    check("t3_seq", host.snap_seq, expSeq);

    // Lock across one capture: shadow holds it until release
    host.lock_req = 1'b1;
    setCh(0, 16'h0033);
    waitTick("lk1", -1);
    step(2);
    check("lk1_seq", host.snap_seq, expSeq);
    rd("lk1_stat", 3'd4, statusW(expSeq, 1, 0, 1));
    rd("lk1_front", 3'd0, 16'h0005);
    host.lock_req = 1'b0;
    step(1);
    expSeq++;
    check("rel1_seq", host.snap_seq, expSeq);
    check("rel1_ack", host.lock_ack, 0);
    rd("rel1_ch0", 3'd0, 16'h0033);
    rd("rel1_stat", 3'd4, statusW(expSeq, 0, 0, 0));

    // Lock across two captures: overrun, second capture wins
    host.lock_req = 1'b1;
    setCh(0, 16'h0044);
    waitTick("lk2a", -1);
    step(2);
    setCh(0, 16'h0055);
    waitTick("lk2b", -1);
    step(2);
    check("lk2_ovr", host.overrun, 1);
    rd("lk2_stat", 3'd4, statusW(expSeq, 1, 1, 1));
    host.lock_req = 1'b0;
    step(1);
    expSeq++;
    check("rel2_seq", host.snap_seq, expSeq);
    check("rel2_ovr", host.overrun, 1);
    rd("rel2_ch0", 3'd0, 16'h0055);
    host.clr_ovr = 1'b1;
    step(1);
    host.clr_ovr = 1'b0;
    check("clr_ovr", host.overrun, 0);

    // Release on the capture edge with a pending shadow
    host.lock_req = 1'b1;
    setCh(0, 16'h0066);
    waitTick("lk3a", -1);
    step(2);
    setCh(0, 16'h0077);
    waitTick("lk3b", -1);
    step(1);
    host.lock_req = 1'b0;
    step(1);
    expSeq++;
    check("relcap_seq", host.snap_seq, expSeq);
    check("relcap_ovr", host.overrun, 1);
    rd("relcap_ch0", 3'd0, 16'h0077);
    rd("relcap_stat", 3'd4, statusW(expSeq, 0, 1, 0));
    host.clr_ovr = 1'b1;
    step(1);
    host.clr_ovr = 1'b0;
    check("clr_ovr2", host.overrun, 0);

    // Sequence number wrap
    while (expSeq != 8'hFF) begin
      waitTick("wrap", -1);
      step(2);
      expSeq++;
    end
    check("seq255", host.snap_seq, 8'hFF);
    waitTick("wrapLast", -1);
    step(2);
    expSeq++;
    check("seqWrap", host.snap_seq, 8'h00);

    // Enable dropped mid-window: no ticks, banks kept, restart from 0
    step(3);
    enable = 1'b0;
    tickCount = 0;
    repeat (20) begin
      step(1);
      if (sample_tick) tickCount++;
    end
    check("dis_noTick", tickCount, 0);
    check("dis_seq", host.snap_seq, expSeq);
    enable = 1'b1;
    host.lock_req = 1'b1;
    host.rd_addr = 3'd4;
    waitTick("restart", P - 1);

    // Asynchronous reset while in TICK: immediate clear, no capture
    reset_n = 1'b0;
    #1;
    check("arst_tick", sample_tick, 0);
    check("arst_ack", host.lock_ack, 0);
    check("arst_rd", host.rd_data, 16'h0000);
    check("arst_seq", host.snap_seq, 8'd0);
    check("arst_valid", host.snap_valid, 0);
    host.lock_req = 1'b0;
    step(2);
    check("arst_hold", host.snap_seq, 8'd0);
    reset_n = 1'b1;
    waitTick("post", P - 1);
    step(1);
    check("post_noCap", host.snap_seq, 8'd0);
    step(1);
    check("post_seq", host.snap_seq, 8'd1);
    rd("post_ch0", 3'd0, 16'h0077);
    rd("post_ch1", 3'd1, 16'hFFFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
